// File: rtl/pc_seq.sv
// Multicycle next-PC sequencer: drives PC mux select, PC/EPC load enables and
// the exception vector fetch (save EPC, read handler address, load PC).
module pc_seq #(
   parameter int          MEM_WAIT = 2,
   parameter logic [31:0] VEC_BASE = 32'd253
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [2:0]  req_kind,
   input  logic        cond,
   input  logic [1:0]  exc_cause,
   output logic [2:0]  pc_sel,
   output logic        pc_write,
   output logic        epc_write,
   output logic        vec_en,
   output logic [31:0] vec_addr,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {IDLE, UPDATE, EXC_EPC, EXC_WAIT, EXC_LOAD} state_t;

   localparam logic [2:0] K_SEQ    = 3'd0;
   localparam logic [2:0] K_BRANCH = 3'd1;
   localparam logic [2:0] K_JUMP   = 3'd2;
   localparam logic [2:0] K_JR     = 3'd3;
   localparam logic [2:0] K_RTE    = 3'd4;
   localparam logic [2:0] K_EXC    = 3'd5;

   localparam logic [2:0] SEL_MEM    = 3'b000;
   localparam logic [2:0] SEL_RESULT = 3'b001;
   localparam logic [2:0] SEL_ALU    = 3'b010;
   localparam logic [2:0] SEL_HOLD   = 3'b011;
   localparam logic [2:0] SEL_LS     = 3'b100;
   localparam logic [2:0] SEL_EPC    = 3'b101;
   localparam logic [2:0] SEL_CONCAT = 3'b110;

   state_t     state;
   logic [3:0] cnt;

   // Reserved cause 3 shares the invalid-opcode vector.
   function automatic logic [31:0] vec_of(input logic [1:0] c);
      logic [1:0] idx;
      idx = (c == 2'd3) ? 2'd0 : c;
      return VEC_BASE + {30'd0, idx};
   endfunction

   // Returns {pc_sel, pc_write} for a single-cycle update request.
   function automatic logic [3:0] upd_ctl(input logic [2:0] kind, input logic c);
      case (kind)
         K_SEQ:    return {SEL_RESULT, 1'b1};
         K_BRANCH: return {SEL_ALU,    c};
         K_JUMP:   return {SEL_CONCAT, 1'b1};
         K_JR:     return {SEL_LS,     1'b1};
         K_RTE:    return {SEL_EPC,    1'b1};
         default:  return {SEL_HOLD,   1'b0};
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pc_sel    <= SEL_HOLD;
         pc_write  <= 1'b0;
         epc_write <= 1'b0;
         vec_en    <= 1'b0;
         vec_addr  <= 32'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cnt       <= 4'd0;
      end else begin
         // Strobes default low each cycle; only the current transition raises them.
         pc_sel    <= SEL_HOLD;
         pc_write  <= 1'b0;
         epc_write <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  busy <= 1'b1;
                  if (req_kind == K_EXC) begin
                     state     <= EXC_EPC;
                     epc_write <= 1'b1;
                     vec_en    <= 1'b1;
                     vec_addr  <= vec_of(exc_cause);
                     cnt       <= 4'(MEM_WAIT - 1);
                  end else begin
                     state              <= UPDATE;
                     {pc_sel, pc_write} <= upd_ctl(req_kind, cond);
                     done               <= 1'b1;
                  end
               end
            end
            UPDATE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            EXC_EPC: begin
               state <= EXC_WAIT;
            end
            EXC_WAIT: begin
               if (cnt == 4'd0) begin
                  state    <= EXC_LOAD;
                  pc_sel   <= SEL_MEM;
                  pc_write <= 1'b1;
                  done     <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            EXC_LOAD: begin
               state  <= IDLE;
               busy   <= 1'b0;
               vec_en <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               vec_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: request kinds, exception entry, reset and
// busy-drop behaviour, with hand-computed expected controls per cycle.
module tb_pc_seq;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic [2:0]  req_kind;
   logic        cond;
   logic [1:0]  exc_cause;
   logic [2:0]  pc_sel;
   logic        pc_write;
   logic        epc_write;
   logic        vec_en;
   logic [31:0] vec_addr;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   pc_seq #(.MEM_WAIT(2), .VEC_BASE(32'd253)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_kind  (req_kind),
      .cond      (cond),
      .exc_cause (exc_cause),
      .pc_sel    (pc_sel),
      .pc_write  (pc_write),
      .epc_write (epc_write),
      .vec_en    (vec_en),
      .vec_addr  (vec_addr),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed order: {pc_sel[2:0], pc_write, epc_write, vec_en, busy, done}
   localparam logic [7:0] IDLE_V = 8'b011_0_0_0_0_0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [7:0] exp);
      chk(tag, {24'd0, pc_sel, pc_write, epc_write, vec_en, busy, done}, {24'd0, exp});
   endtask

   task automatic req(input logic [2:0] k, input logic c, input logic [1:0] cause);
      req_valid = 1'b1;
      req_kind  = k;
      cond      = c;
      exc_cause = cause;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_kind  = 3'd0;
      cond      = 1'b0;
      exc_cause = 2'd0;
      repeat (2) @(negedge clk);
      chk_ctl("reset_ctl", IDLE_V);
      chk("reset_vec", vec_addr, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk_ctl("idle_after_reset", IDLE_V);

      // SEQ
      req(3'd0, 1'b0, 2'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk_ctl("seq_update", 8'b001_1_0_0_1_1);
      @(negedge clk);
      chk_ctl("seq_idle", IDLE_V);

      // BRANCH not taken, then taken
      req(3'd1, 1'b0, 2'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk_ctl("br_nt", 8'b010_0_0_0_1_1);
      @(negedge clk);
      chk_ctl("br_nt_idle", IDLE_V);
      req(3'd1, 1'b1, 2'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk_ctl("br_t", 8'b010_1_0_0_1_1);
      @(negedge clk);
      chk_ctl("br_t_idle", IDLE_V);

      // JUMP with req_valid held through UPDATE: accepted once only
      req(3'd2, 1'b0, 2'd0);
      @(negedge clk);
      chk_ctl("jump", 8'b110_1_0_0_1_1);
      @(negedge clk);
      chk_ctl("jump_held_ignored", IDLE_V);
      // JR, with an EXC request presented while busy that must be dropped
      req(3'd3, 1'b0, 2'd0);
      @(negedge clk);
      chk_ctl("jr", 8'b100_1_0_0_1_1);
      req(3'd5, 1'b0, 2'd1);
      @(negedge clk);
      chk_ctl("exc_while_busy_ignored", IDLE_V);
      req(3'd4, 1'b0, 2'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk_ctl("rte", 8'b101_1_0_0_1_1);
      @(negedge clk);
      chk_ctl("rte_idle", IDLE_V);

      // Exception, cause 1
      req(3'd5, 1'b0, 2'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk_ctl("exc1_epc", 8'b011_0_1_1_1_0);
      chk("exc1_vec", vec_addr, 32'd254);
      @(negedge clk);
      chk_ctl("exc1_wait1", 8'b011_0_0_1_1_0);
      chk("exc1_vec_hold", vec_addr, 32'd254);
      @(negedge clk);
      chk_ctl("exc1_wait2", 8'b011_0_0_1_1_0);
      @(negedge clk);
      chk_ctl("exc1_load", 8'b000_1_0_1_1_1);
      @(negedge clk);
      chk_ctl("exc1_idle", IDLE_V);
      chk("exc1_vec_after", vec_addr, 32'd254);

      // Exception, reserved cause 3 maps to base
      req(3'd5, 1'b0, 2'd3);
      @(negedge clk);
      req_valid = 1'b0;
      chk_ctl("exc3_epc", 8'b011_0_1_1_1_0);
      chk("exc3_vec", vec_addr, 32'd253);
      repeat (2) @(negedge clk);
      chk_ctl("exc3_wait2", 8'b011_0_0_1_1_0);
      @(negedge clk);
      chk_ctl("exc3_load", 8'b000_1_0_1_1_1);
      @(negedge clk);
      chk_ctl("exc3_idle", IDLE_V);

      // Reserved kinds
      req(3'd7, 1'b1, 2'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk_ctl("rsv7", 8'b011_0_0_0_1_1);
      @(negedge clk);
      req(3'd6, 1'b1, 2'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk_ctl("rsv6", 8'b011_0_0_0_1_1);
      @(negedge clk);
      chk_ctl("rsv6_idle", IDLE_V);

      // Reset mid-EXC_WAIT, cause 2
      req(3'd5, 1'b0, 2'd2);
      @(negedge clk);
      req_valid = 1'b0;
      chk("exc2_vec", vec_addr, 32'd255);
      @(negedge clk);
      chk_ctl("exc2_wait1", 8'b011_0_0_1_1_0);
      reset = 1'b1;
      @(negedge clk);
      chk_ctl("rst_mid_wait", IDLE_V);
      chk("rst_mid_vec", vec_addr, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk_ctl("rst_no_load", IDLE_V);
      @(negedge clk);
      chk_ctl("rst_still_idle", IDLE_V);

      // Reset wins over a simultaneous request
      reset = 1'b1;
      req(3'd0, 1'b0, 2'd0);
      @(negedge clk);
      chk_ctl("rst_vs_req", IDLE_V);
      reset = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      chk_ctl("rst_vs_req_after", IDLE_V);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
